// File: rtl/seq_mult_pkg.sv
// Shared types and width helpers for the sequential shift-and-add multiplier.
// Holds the controller state enum, the counter-width and product-width functions.
package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must represent 0..qw, hence clog2(qw+1).
   function automatic int cnt_w(input int qw);
      return (qw < 1) ? 1 : $clog2(qw + 1);
   endfunction

   function automatic int prod_w(input int mkw, input int qw);
      return mkw + qw;
   endfunction

endpackage

// File: rtl/mult_add_row.sv
// One AND-gated adder row: sum = hi + (lsb ? mk_r : 0), ripple of full adders.
// Ports: mk_r (MK_W), lsb (1), hi (MK_W) in; sum (MK_W+1, incl. carry out) out.
module mult_add_row #(
   parameter int MK_W = 3
) (
   input  logic [MK_W-1:0] mk_r,
   input  logic            lsb,
   input  logic [MK_W-1:0] hi,
   output logic [MK_W:0]   sum
);

   logic [MK_W:0]   c;
   logic [MK_W-1:0] pp;

   assign c[0] = 1'b0;

   for (genvar i = 0; i < MK_W; i++) begin : g_fa
      assign pp[i]   = mk_r[i] & lsb;
      assign sum[i]  = hi[i] ^ pp[i] ^ c[i];
      assign c[i+1]  = (hi[i] & pp[i]) | (c[i] & (hi[i] ^ pp[i]));
   end

   assign sum[MK_W] = c[MK_W];

endmodule

// File: rtl/seq_mult_ctrl.sv
// Iterative MK_W x Q_W unsigned multiplier with start/busy/done handshake.
// Ports: clk, rst (sync, active-high), start, mk, q in; busy, done, product out.
// Build option SEQ_MULT_EARLY_EXIT_EN: finish as soon as remaining q bits are zero.
module seq_mult_ctrl
   import seq_mult_pkg::*;
#(
   parameter int MK_W = 3,
   parameter int Q_W  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [MK_W-1:0]      mk,
   input  logic [Q_W-1:0]       q,
   output logic                 busy,
   output logic                 done,
   output logic [MK_W+Q_W-1:0]  product
);

   localparam int CW  = cnt_w(Q_W);
   localparam int P_W = prod_w(MK_W, Q_W);

   state_t state, nxt_state;

   logic [MK_W-1:0] mk_r;
   // The accumulator's top bit is always zero after the shift, so only
   // the MK_W bits that feed the adder row are stored.
   logic [MK_W-1:0] hi;
   logic [Q_W-1:0]  lo;
   logic [CW-1:0]   cnt;

   logic [MK_W:0]   sum;
   logic [P_W-1:0]  nxt;
   logic [P_W-1:0]  fin;
   logic            last;

   mult_add_row #(
      .MK_W(MK_W)
   ) u_row (
      .mk_r (mk_r),
      .lsb  (lo[0]),
      .hi   (hi),
      .sum  (sum)
   );

   // One step: {sum,lo} shifted right by one.
   assign nxt = P_W'({sum, lo} >> 1);

`ifdef SEQ_MULT_EARLY_EXIT_EN
   logic [CW-1:0] shamt;
   logic          rem;

   // Remaining multiplier bits after this step are lo[Q_W-1-cnt:1].
   always_comb begin
      rem = 1'b0;
      for (int i = 1; i < Q_W; i++) begin
         if ((i <= Q_W - 1 - int'(cnt)) && lo[i]) rem = 1'b1;
      end
   end

   // Apply all outstanding right shifts at once.
   assign shamt = CW'(Q_W) - cnt;
   assign fin   = P_W'({sum, lo} >> shamt);
   assign last  = ~rem;
`else
   assign fin  = nxt;
   assign last = (cnt == CW'(Q_W - 1));
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      unique case (state)
         IDLE:    nxt_state = start ? RUN : IDLE;
         RUN:     nxt_state = last ? DONE : RUN;
         DONE:    nxt_state = start ? RUN : IDLE;
         default: nxt_state = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mk_r    <= '0;
         hi      <= '0;
         lo      <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  mk_r <= mk;
                  hi   <= '0;
                  lo   <= q;
                  cnt  <= '0;
               end
            end
            RUN: begin
               hi  <= nxt[P_W-1:Q_W];
               lo  <= nxt[Q_W-1:0];
               cnt <= cnt + CW'(1);
               if (last) product <= fin;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed self-checking bench for seq_mult_ctrl (MK_W=3, Q_W=2).
// Drives inputs and samples outputs 1ns after each rising edge.
module tb_seq_mult_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [2:0] mk;
   logic [1:0] q;
   logic       busy;
   logic       done;
   logic [4:0] product;

   int checks = 0;
   int errors = 0;

   seq_mult_ctrl #(
      .MK_W(3),
      .Q_W (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .mk      (mk),
      .q       (q),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_lat(input int qv);
`ifdef SEQ_MULT_EARLY_EXIT_EN
      return (qv >= 2) ? 2 : 1;
`else
      return 2;
`endif
   endfunction

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; mk = '0; q = '0;
      step(); step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 5'd0) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b product=%0d, need 0 0 0",
                  busy, done, product);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      int lat;
      start = 1'b1; mk = 3'd7; q = 2'd3;
      step();
      start = 1'b0; mk = 3'd0; q = 2'd0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL basic_run1: busy=%b done=%b, need 1 0", busy, done);
      end
      lat = 0;
      while (done !== 1'b1 && lat < 10) begin
         if (busy !== 1'b1) break;
         step();
         lat++;
      end
      checks++;
      if (lat != exp_lat(3) || done !== 1'b1) begin
         errors++;
         $display("FAIL basic_lat: lat=%0d done=%b, need %0d 1",
                  lat, done, exp_lat(3));
      end
      checks++;
      if (product !== 5'd21 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_prod: product=%0d busy=%b, need 21 0",
                  product, busy);
      end
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 5'd21) begin
         errors++;
         $display("FAIL basic_hold: busy=%b done=%b product=%0d, need 0 0 21",
                  busy, done, product);
      end
   endtask

   task automatic test_sweep();
      int lat;
      logic [4:0] expv;
      for (int a = 0; a < 8; a++) begin
         for (int b = 0; b < 4; b++) begin
            start = 1'b1; mk = 3'(a); q = 2'(b);
            step();
            start = 1'b0; mk = ~mk; q = ~q;
            lat = 0;
            while (done !== 1'b1 && lat < 10) begin
               step();
               lat++;
            end
            expv = 5'(a * b);
            checks++;
            if (done !== 1'b1 || lat != exp_lat(b) || product !== expv) begin
               errors++;
               $display("FAIL sweep %0dx%0d: product=%0d lat=%0d, need %0d lat %0d",
                        a, b, product, lat, expv, exp_lat(b));
            end
            step();
         end
      end
   endtask

   task automatic test_ignore_start();
      int lat;
      start = 1'b1; mk = 3'd5; q = 2'd2;
      step();
      mk = 3'd7; q = 2'd3;
      step();
      start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 10) begin
         step();
         lat++;
      end
      checks++;
      if (done !== 1'b1 || lat != 2 || product !== 5'd10) begin
         errors++;
         $display("FAIL ignore_start: product=%0d lat=%0d, need 10 lat 2",
                  product, lat);
      end
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 5'd10) begin
         errors++;
         $display("FAIL ignore_idle: busy=%b done=%b product=%0d, need 0 0 10",
                  busy, done, product);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      start = 1'b1; mk = 3'd6; q = 2'd3;
      step();
      lat = 0;
      while (done !== 1'b1 && lat < 10) begin
         step();
         lat++;
         mk = 3'd3; q = 2'd1;
      end
      checks++;
      if (done !== 1'b1 || product !== 5'd18) begin
         errors++;
         $display("FAIL b2b_first: product=%0d done=%b, need 18 1",
                  product, done);
      end
      step();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_noidle: busy=%b done=%b, need 1 0", busy, done);
      end
      lat = 0;
      while (done !== 1'b1 && lat < 10) begin
         step();
         lat++;
      end
      checks++;
      if (done !== 1'b1 || lat != exp_lat(1) || product !== 5'd3) begin
         errors++;
         $display("FAIL b2b_second: product=%0d lat=%0d, need 3 lat %0d",
                  product, lat, exp_lat(1));
      end
      step();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_pulse: done=%b, need 0", done);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      start = 1'b1; mk = 3'd7; q = 2'd3;
      step();
      start = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 5'd0) begin
         errors++;
         $display("FAIL reset_mid: busy=%b done=%b product=%0d, need 0 0 0",
                  busy, done, product);
      end
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b done=%b, need 0 0", busy, done);
      end
      start = 1'b1; mk = 3'd2; q = 2'd2;
      step();
      start = 1'b0;
      lat = 0;
      while (done !== 1'b1 && lat < 10) begin
         step();
         lat++;
      end
      checks++;
      if (done !== 1'b1 || product !== 5'd4) begin
         errors++;
         $display("FAIL reset_fresh: product=%0d done=%b, need 4 1",
                  product, done);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sweep();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_mult_ctrl.md
Name: seq_mult_ctrl

Overview:
Iterative shift-and-add multiplier controller. It time-multiplexes a single MK_W-wide AND-gated adder row across Q_W cycles to form an MK_W x Q_W unsigned product, one multiplier bit per cycle. It is the sequential, area-reduced counterpart of the combinational array multiplier and presents a start/busy/done handshake to upstream logic.

Parameters:
MK_W, 3, multiplicand width in bits (>=2)
Q_W, 2, multiplier width in bits (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request to begin a multiply; sampled only when the controller can accept
mk  input  MK_W  multiplicand, sampled on the accepting edge
q  input  Q_W  multiplier, sampled on the accepting edge
busy  output  1  high while an operation is in RUN
done  output  1  one-cycle pulse; product valid
product  output  MK_W+Q_W  result; held until the next accepted start

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: the state goes to IDLE. busy=0, done=0, product=0. All internal registers (hi, lo, mk_r, cnt) are cleared. Reset overrides every other input on the same edge, including in the middle of an operation; the partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1: latch mk_r=mk, hi=0 (MK_W+1 bits), lo=q (Q_W bits), cnt=0, go to RUN. With start=0, IDLE stays in IDLE and DONE goes to IDLE.
- RUN, once per edge:
  - pp = lo[0] ? mk_r : 0.
  - sum = hi[MK_W-1:0] + pp, MK_W+1 bits including the carry out of the add row.
  - {hi,lo} <= {sum, lo} >> 1, a logical right shift by one across MK_W+1+Q_W bits.
  - cnt <= cnt+1.
  - When the final step completes (cnt==Q_W-1 on that edge), go to DONE and load product <= low MK_W+Q_W bits of the shifted {hi,lo}.
- Outputs: busy = (state==RUN). done = (state==DONE).
- Latency: start accepted at edge E0 -> RUN for Q_W edges -> done=1 during the cycle after edge E0+Q_W. Product is valid in that cycle and held afterwards.
- start while RUN: ignored. No queuing and no error flag.
- Back-to-back: start=1 in the DONE cycle is accepted. done is still a single-cycle pulse, and the next operation begins without passing through IDLE.
- Operand changes after acceptance have no effect, because the operands are registered.
- Widths: the product never overflows, since MK_W+Q_W bits hold the maximum (2^MK_W-1)(2^Q_W-1). cnt width is clog2(Q_W+1).
- Q_W=1: RUN lasts exactly one edge.

Optional Feature:
SEQ_MULT_EARLY_EXIT_EN
- Defined: on any RUN edge where the post-shift remaining multiplier bits (upper Q_W-1-cnt bits of lo before the shift) are all zero, the controller finishes early. It loads product = the fully aligned result, with the remaining right shifts applied combinationally, and goes to DONE. Latency becomes 1 + index of the highest set bit of q, and is 1 cycle when q=0. Product values are identical to the non-early-exit build.
- Undefined: every operation takes exactly Q_W RUN cycles.

Decomposition:
- Package seq_mult_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - localparam-style function for the cnt width (clog2)
  - product width constant expression MK_W+Q_W
- Sub-module mult_add_row: combinational. Inputs mk_r, lo[0], hi[MK_W-1:0]. Output MK_W+1-bit sum. Built as an AND-gated ripple chain of full adders per bit, with carry-in 0 at the LSB. The controller instantiates one copy.

Test Plan:
- Reset then mk=7, q=3, pulse start: busy=1 for 2 cycles; done=1 on the 3rd cycle after the start edge; product=21; busy=0 and done=0 after that, and product stays 21.
- Exhaustive sweep with defaults: all 8x4 operand pairs, each checked against mk*q. Includes mk=0 -> product=0 and q=0 -> product=0. Without EARLY_EXIT, latency is always 2.
- mk=5, q=2 accepted, then start with mk=7, q=3 asserted during RUN: the second start is ignored and product=10.
- Back-to-back: start held high across DONE with mk=6, q=3 then mk=3, q=1: products 18 then 3, done pulses in two separate cycles, no IDLE cycle between them.
- rst asserted on the 1st RUN cycle of mk=7, q=3: the next edge gives IDLE, busy=0, done=0, product=0. A fresh start with mk=2, q=2 yields 4.
- With SEQ_MULT_EARLY_EXIT_EN, MK_W=3, Q_W=2: q=1, mk=7 -> done after 1 RUN cycle, product=7. q=0 -> 1 cycle, product=0. q=2 -> 2 cycles, product=14.
